seq_miter_cmp: RTL

- Clocked, streaming successor to the combinational gold/gate output comparator used in equivalence miters.
- Accepts valid/ready streams from a gold and a gate instance whose results may arrive at different cycles.
- Aligns the two streams in per-side FIFOs and compares them pairwise, masking gold don't-care bits.
- Keeps sticky fail/desync status, saturating counters and a capture of the first mismatch.
- Sits between DUT pairs and the property/cover layer of the sequential equivalence benches.

---
 rtl/seq_miter_pkg.sv | 36 +++
 rtl/miter_sync_fifo.sv | 62 ++++++
 rtl/seq_miter_cmp.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_miter_pkg.sv
// Shared types and helpers for the streaming gold/gate miter comparator.
// Holds the FSM encoding, the masked compare and the counter saturation value.
package seq_miter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] word_t;

   // Operands are zero-extended to MAX_W by the caller; a set xmask bit
   // removes that bit from the compare.
   function automatic logic masked_mismatch(
      input word_t gold,
      input word_t gate,
      input word_t xmask
   );
      return |((gold ^ gate) & ~xmask);
   endfunction

   function automatic word_t sat_max(input int cnt_w);
      word_t v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < cnt_w) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/miter_sync_fifo.sv
// Single-clock pointer FIFO with an extra wrap bit for full/empty.
// Async active-low reset plus a synchronous flush; head is read combinationally.
module miter_sync_fifo
   import seq_miter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign dout = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/seq_miter_cmp.sv
// Streaming gold/gate miter: aligns both sides in FIFOs, compares masked pairs.
// Optional property checks are enabled with the SEQ_MITER_ASSERT_EN macro.
module seq_miter_cmp
   import seq_miter_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 4,
   parameter int CNT_W        = 16,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             gold_valid,
   input  logic [WIDTH-1:0] gold_data,
   input  logic [WIDTH-1:0] gold_xmask,
   output logic             gold_ready,
   input  logic             gate_valid,
   input  logic [WIDTH-1:0] gate_data,
   output logic             gate_ready,
   output logic             cmp_valid,
   output logic             cmp_ok,
   output logic             fail,
   output logic             desync,
   output logic [CNT_W-1:0] cmp_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_idx,
   output logic [WIDTH-1:0] first_gold,
   output logic [WIDTH-1:0] first_gate,
   output logic [1:0]       state
);

   localparam int GW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam bit STOP = (STOP_ON_FAIL != 0);

   state_t           st;
   logic [GW-1:0]    g_head;
   logic [WIDTH-1:0] h_gold;
   logic [WIDTH-1:0] h_mask;
   logic [WIDTH-1:0] t_head;
   logic             g_full;
   logic             g_empty;
   logic             t_full;
   logic             t_empty;
   logic             halted;
   logic             gold_push;
   logic             gate_push;
   logic             do_cmp;
   logic             mis;
   logic             desync_now;

   assign halted = STOP && (st == ST_FAIL);

   assign gold_ready = !g_full && !halted;
   assign gate_ready = !t_full && !halted;
   assign gold_push  = gold_valid && gold_ready;
   assign gate_push  = gate_valid && gate_ready;

   assign do_cmp = !g_empty && !t_empty && !halted;

   assign {h_mask, h_gold} = g_head;

   assign mis = masked_mismatch(word_t'(h_gold),
                                word_t'(t_head),
                                word_t'(h_mask));

   assign desync_now = (g_full && t_empty) || (t_full && g_empty);

   assign state = st;

   miter_sync_fifo #(
      .WIDTH (GW),
      .DEPTH (DEPTH)
   ) u_gold_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clr),
      .push  (gold_push),
      .din   ({gold_xmask, gold_data}),
      .pop   (do_cmp),
      .dout  (g_head),
      .full  (g_full),
      .empty (g_empty)
   );

   miter_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_gate_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clr),
      .push  (gate_push),
      .din   (gate_data),
      .pop   (do_cmp),
      .dout  (t_head),
      .full  (t_full),
      .empty (t_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= ST_IDLE;
         cmp_valid  <= 1'b0;
         cmp_ok     <= 1'b0;
         fail       <= 1'b0;
         desync     <= 1'b0;
         cmp_count  <= '0;
         err_count  <= '0;
         first_idx  <= '0;
         first_gold <= '0;
         first_gate <= '0;
      end else if (clr) begin
         // A compare due on this edge is dropped along with the FIFOs.
         st         <= ST_IDLE;
         cmp_valid  <= 1'b0;
         cmp_ok     <= 1'b0;
         fail       <= 1'b0;
         desync     <= 1'b0;
         cmp_count  <= '0;
         err_count  <= '0;
         first_idx  <= '0;
         first_gold <= '0;
         first_gate <= '0;
      end else begin
         cmp_valid <= do_cmp;
         cmp_ok    <= do_cmp && !mis;
         if (desync_now) begin
            desync <= 1'b1;
         end
         if (do_cmp) begin
            if (cmp_count != CNT_MAX) begin
               cmp_count <= cmp_count + CNT_ONE;
            end
            if (mis) begin
               if (err_count != CNT_MAX) begin
                  err_count <= err_count + CNT_ONE;
               end
               if (!fail) begin
                  first_idx  <= cmp_count;
                  first_gold <= h_gold;
                  first_gate <= t_head;
               end
               fail <= 1'b1;
               st   <= ST_FAIL;
            end else if (st == ST_IDLE) begin
               st <= ST_RUN;
            end
         end
      end
   end

`ifdef SEQ_MITER_ASSERT_EN
   always @(posedge clk) begin
      if (rst_n && cmp_valid) begin
         assert (cmp_ok);
      end
      if (rst_n) begin
         assert (!desync);
      end
   end

   cover property (@(posedge clk) disable iff (!rst_n) cmp_valid && cmp_ok);
`endif

endmodule
